usb_host_xfer: RTL and testbench
================================

USB_HOST_XFER -- requirements
Module: usb_host_xfer

Interface
REQ-001 Parameters, one per line (name, default, meaning): RESP_TIMEOUT, 92, clk cycles to wait for a handshake or data PID. MAX_RETRY, 3, re-issues allowed after NAK, timeout or CRC error. MAX_PKT, 512, maximum OUT payload bytes per packet.
REQ-002 Ports, one per line (name  direction  width  meaning); clock and reset first. One clock; reset is synchronous and active-low.
clk  in  1  sole clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid / req_ready  in/out  1/1  transaction request handshake
req_type  in  2  00 OUT, 10 IN, 11 SETUP
req_addr / req_ep  in  7/4  device address / endpoint
req_len  in  10  OUT/SETUP payload bytes (SETUP forced to 8)
tok_start / tok_type / tok_addr / tok_ep  out  1/2/7/4  token request to packet TX
tok_sent  in  1  token transmitted, one-cycle pulse
tx_data_start / tx_data_type  out  1/2  data packet active / PID (DATA0=00, DATA1=10)
s_tdata / s_tvalid / s_tready  in/in/out  8/1/1  OUT payload source stream
tx_tdata / tx_tvalid / tx_tready / tx_tlast  out/out/in/out  8/1/1/1  payload to packet TX
rx_tdata / rx_tvalid / rx_end / rx_data_type  in  8/1/1/2  received data packet
rx_hsk_recv / rx_hsk_type  in  1/2  received handshake (00 ACK, 10 NAK, 11 STALL, 01 NYET)
crc_error  in  1  CRC16 failure; valid with rx_end
tx_hsk_send / tx_hsk_type / tx_hsk_sent  out/out/in  1/2/1  host ACK request, type, completion
m_tdata / m_tvalid  out  8/1  IN payload to consumer; no backpressure
done / status / rx_count  out  1/3/10  completion pulse, result, IN bytes received

Function
REQ-003 States: IDLE, TOKEN, TX_DATA, WAIT_RESP, RX_DATA, SEND_ACK, DONE.
REQ-004 req_ready SHALL be 1 only in IDLE; request fields SHALL be latched when req_valid && req_ready; next state TOKEN; retry counter cleared.
REQ-005 TOKEN: tok_start SHALL hold 1 with latched fields until tok_sent; then IN -> WAIT_RESP, OUT/SETUP -> TX_DATA.
REQ-006 TX_DATA: tx_data_start=1; tx_data_type SHALL be DATA0 for SETUP, else {toggle[ep],0}; tx_tvalid=s_tvalid, s_tready=tx_tready; tx_tlast SHALL assert on byte count==len-1 or MAX_PKT-1; transfer on tvalid&&tready.
REQ-007 Zero-length OUT: tx_data_start and tx_tlast SHALL assert together for exactly one cycle with tx_tvalid=0, then WAIT_RESP.
REQ-008 WAIT_RESP: timeout counter cleared on entry, increments per cycle; reaching RESP_TIMEOUT-1 SHALL count as timeout.
REQ-009 OUT/SETUP handshake: ACK -> toggle[ep]^=1 (SETUP sets toggle[ep]=1), status 0; NYET -> as ACK, status 1; STALL -> status 3, no retry; NAK or timeout -> retry.
REQ-010 IN: first rx_tvalid -> RX_DATA, timeout disabled; m_tdata=rx_tdata, m_tvalid=rx_tvalid in RX_DATA only; rx_count increments per byte, saturates at 1023.
REQ-011 IN handshake in WAIT_RESP: NAK or timeout -> retry; STALL -> status 3.
REQ-012 RX_DATA on rx_end: crc_error -> no handshake, retry with reason CRC; else SEND_ACK; rx_data_type matching toggle[ep] -> toggle flips, status 0; mismatch -> toggle unchanged, status 6 (duplicate).
REQ-013 SEND_ACK: tx_hsk_send=1, tx_hsk_type=00 until tx_hsk_sent, then DONE.
REQ-014 Retry: retries<MAX_RETRY -> increment, return to TOKEN (OUT payload re-supplied by source); else DONE with status 2 NAK, 4 TIMEOUT, 5 CRC per last reason.
REQ-015 DONE: done=1 one cycle; status, rx_count hold until next request accepted; next state IDLE.
REQ-016 Simultaneous rx_hsk_recv and timeout terminal count: handshake SHALL win.
REQ-017 Toggles: 16-bit vector indexed by req_ep, shared by IN and OUT.

Reset
REQ-018 rst_n low at a clk edge SHALL force IDLE, toggles 0, counters 0, every output 0 except req_ready=1 from the first cycle after release.
REQ-019 Reset mid-transaction SHALL abort with no done pulse and no handshake issued.

Verification
REQ-020 OUT ep1 len 4, bytes 11 22 33 44, device ACK -> DATA0 sent, tx_tlast on 44, done, status 0, toggle[1]=1.
REQ-021 IN ep2, DATA0 of 3 bytes, good CRC -> m_tvalid x3, ACK sent, rx_count=3, status 0; repeat with DATA0 -> ACK, status 6, toggle[2] stays 1.
REQ-022 SETUP ep0 8 bytes, ACK -> DATA0 PID, toggle[0]=1, status 0.
REQ-023 IN, device NAKs 4 times -> 4 tokens issued, done, status 2; silence instead -> each wait 92 cycles, status 4.
REQ-024 IN with crc_error on rx_end -> no ACK, token re-issued; OUT with STALL -> done, status 3, single token.
REQ-025 rst_n low during TX_DATA -> tok_start, tx_data_start, done all 0; req_ready=1 next cycle.

Source files
------------

// File: rtl/usb_host_xfer.sv
// USB host transaction engine: issues a token, moves OUT/SETUP payload or receives IN
// data, handles handshakes, per-endpoint data toggles and bounded retries.
module usb_host_xfer #(
  parameter int RESP_TIMEOUT = 92,
  parameter int MAX_RETRY    = 3,
  parameter int MAX_PKT      = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [6:0]  req_addr,
  input  logic [3:0]  req_ep,
  input  logic [9:0]  req_len,
  output logic        tok_start,
  output logic [1:0]  tok_type,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_ep,
  input  logic        tok_sent,
  output logic        tx_data_start,
  output logic [1:0]  tx_data_type,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        tx_tlast,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  input  logic        rx_end,
  input  logic [1:0]  rx_data_type,
  input  logic        rx_hsk_recv,
  input  logic [1:0]  rx_hsk_type,
  input  logic        crc_error,
  output logic        tx_hsk_send,
  output logic [1:0]  tx_hsk_type,
  input  logic        tx_hsk_sent,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        done,
  output logic [2:0]  status,
  output logic [9:0]  rx_count
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_TOKEN, ST_TX_DATA, ST_WAIT_RESP, ST_RX_DATA, ST_SEND_ACK, ST_DONE
  } state_t;

  localparam logic [1:0] T_IN    = 2'b10;
  localparam logic [1:0] T_SETUP = 2'b11;
  localparam logic [1:0] H_ACK   = 2'b00;
  localparam logic [1:0] H_NYET  = 2'b01;
  localparam logic [1:0] H_STALL = 2'b11;

  state_t      state_r, state_n;
  logic [1:0]  type_r;
  logic [6:0]  addr_r;
  logic [3:0]  ep_r;
  logic [9:0]  len_r;
  logic [9:0]  byte_cnt_r;
  logic [15:0] tmo_r;
  logic [7:0]  retry_r;
  logic [15:0] toggle_r;
  logic [2:0]  status_r;
  logic [9:0]  rx_count_r;
  logic [7:0]  m_tdata_r;
  logic        m_tvalid_r;

  logic accept_s, in_tx_s, zlp_s, last_s, xfer_s, tmo_hit_s, retry_ok_s, rx_in_s;
  logic retry_s, stat_wr_s, tog_wr_s, tog_val_s;
  logic [2:0] stat_val_s;

  assign req_ready     = (state_r == ST_IDLE);
  assign accept_s      = req_valid && req_ready;
  assign tok_start     = (state_r == ST_TOKEN);
  assign tok_type      = type_r;
  assign tok_addr      = addr_r;
  assign tok_ep        = ep_r;
  assign in_tx_s       = (state_r == ST_TX_DATA);
  assign zlp_s         = (len_r == 10'd0);
  assign last_s        = (byte_cnt_r == len_r - 10'd1) || (byte_cnt_r == 10'(MAX_PKT - 1));
  assign tx_data_start = in_tx_s;
  assign tx_data_type  = (in_tx_s && type_r != T_SETUP) ? {toggle_r[ep_r], 1'b0} : 2'b00;
  assign tx_tvalid     = in_tx_s && !zlp_s && s_tvalid;
  assign s_tready      = in_tx_s && !zlp_s && tx_tready;
  assign tx_tdata      = in_tx_s ? s_tdata : 8'd0;
  assign tx_tlast      = in_tx_s && (zlp_s || last_s);
  assign xfer_s        = tx_tvalid && tx_tready;
  assign tmo_hit_s     = (tmo_r == 16'(RESP_TIMEOUT - 1));
  assign retry_ok_s    = (retry_r < 8'(MAX_RETRY));
  // The first IN byte arrives while still waiting, so it is captured there too.
  assign rx_in_s       = (state_r == ST_RX_DATA) ||
                         (state_r == ST_WAIT_RESP && type_r == T_IN && !rx_hsk_recv);
  assign tx_hsk_send   = (state_r == ST_SEND_ACK);
  assign tx_hsk_type   = 2'b00;
  assign done          = (state_r == ST_DONE);
  assign status        = status_r;
  assign rx_count      = rx_count_r;
  assign m_tdata       = m_tdata_r;
  assign m_tvalid      = m_tvalid_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_n;
  end

  // Next-state, status, toggle and retry decisions
  always_comb begin
    state_n    = state_r;
    retry_s    = 1'b0;
    stat_wr_s  = 1'b0;
    stat_val_s = 3'd0;
    tog_wr_s   = 1'b0;
    tog_val_s  = 1'b0;
    case (state_r)
      ST_IDLE:     state_n = accept_s ? ST_TOKEN : ST_IDLE;
      ST_TOKEN: begin
        if (tok_sent) state_n = (type_r == T_IN) ? ST_WAIT_RESP : ST_TX_DATA;
        else          state_n = ST_TOKEN;
      end
      ST_TX_DATA: begin
        if (zlp_s || (xfer_s && last_s)) state_n = ST_WAIT_RESP;
        else                             state_n = ST_TX_DATA;
      end
      ST_WAIT_RESP: begin
        if (rx_hsk_recv) begin
          if (rx_hsk_type == H_STALL) begin
            state_n    = ST_DONE;
            stat_wr_s  = 1'b1;
            stat_val_s = 3'd3;
          end else if (type_r != T_IN && (rx_hsk_type == H_ACK || rx_hsk_type == H_NYET)) begin
            state_n    = ST_DONE;
            stat_wr_s  = 1'b1;
            stat_val_s = (rx_hsk_type == H_NYET) ? 3'd1 : 3'd0;
            tog_wr_s   = 1'b1;
            tog_val_s  = (type_r == T_SETUP) ? 1'b1 : ~toggle_r[ep_r];
          end else begin
            retry_s    = 1'b1;
            state_n    = retry_ok_s ? ST_TOKEN : ST_DONE;
            stat_wr_s  = !retry_ok_s;
            stat_val_s = 3'd2;
          end
        end else if (type_r == T_IN && rx_tvalid) begin
          state_n = ST_RX_DATA;
        end else if (tmo_hit_s) begin
          retry_s    = 1'b1;
          state_n    = retry_ok_s ? ST_TOKEN : ST_DONE;
          stat_wr_s  = !retry_ok_s;
          stat_val_s = 3'd4;
        end else begin
          state_n = ST_WAIT_RESP;
        end
      end
      ST_RX_DATA: begin
        if (rx_end && crc_error) begin
          retry_s    = 1'b1;
          state_n    = retry_ok_s ? ST_TOKEN : ST_DONE;
          stat_wr_s  = !retry_ok_s;
          stat_val_s = 3'd5;
        end else if (rx_end) begin
          state_n    = ST_SEND_ACK;
          stat_wr_s  = 1'b1;
          tog_wr_s   = (rx_data_type == {toggle_r[ep_r], 1'b0});
          tog_val_s  = ~toggle_r[ep_r];
          stat_val_s = tog_wr_s ? 3'd0 : 3'd6;
        end else begin
          state_n = ST_RX_DATA;
        end
      end
      ST_SEND_ACK: state_n = tx_hsk_sent ? ST_DONE : ST_SEND_ACK;
      ST_DONE:     state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  // Request latch, counters, toggles and IN payload register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      type_r     <= 2'b00;
      addr_r     <= 7'd0;
      ep_r       <= 4'd0;
      len_r      <= 10'd0;
      byte_cnt_r <= 10'd0;
      tmo_r      <= 16'd0;
      retry_r    <= 8'd0;
      toggle_r   <= 16'd0;
      status_r   <= 3'd0;
      rx_count_r <= 10'd0;
      m_tdata_r  <= 8'd0;
      m_tvalid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        type_r   <= req_type;
        addr_r   <= req_addr;
        ep_r     <= req_ep;
        len_r    <= (req_type == T_SETUP) ? 10'd8 : req_len;
        retry_r  <= 8'd0;
        status_r <= 3'd0;
      end else if (retry_s && retry_ok_s) begin
        retry_r <= retry_r + 8'd1;
      end
      if (stat_wr_s) status_r <= stat_val_s;
      if (tog_wr_s) toggle_r[ep_r] <= tog_val_s;
      byte_cnt_r <= !in_tx_s ? 10'd0 : (xfer_s ? byte_cnt_r + 10'd1 : byte_cnt_r);
      tmo_r      <= (state_r == ST_WAIT_RESP) ? tmo_r + 16'd1 : 16'd0;
      if (accept_s || state_r == ST_TOKEN) rx_count_r <= 10'd0;
      else if (rx_in_s && rx_tvalid && rx_count_r != 10'd1023) rx_count_r <= rx_count_r + 10'd1;
      m_tvalid_r <= rx_in_s && rx_tvalid;
      m_tdata_r  <= rx_in_s ? rx_tdata : 8'd0;
    end
  end

endmodule

// File: tb/tb_usb_host_xfer.sv
// Directed bench for usb_host_xfer: OUT, IN, SETUP, retries, timeouts, STALL, reset abort.
module tb_usb_host_xfer;

  logic       clk, rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_type;
  logic [6:0] req_addr;
  logic [3:0] req_ep;
  logic [9:0] req_len;
  logic       tok_start, tok_sent;
  logic [1:0] tok_type;
  logic [6:0] tok_addr;
  logic [3:0] tok_ep;
  logic       tx_data_start;
  logic [1:0] tx_data_type;
  logic [7:0] s_tdata, tx_tdata, rx_tdata, m_tdata;
  logic       s_tvalid, s_tready, tx_tvalid, tx_tready, tx_tlast;
  logic       rx_tvalid, rx_end, rx_hsk_recv, crc_error;
  logic [1:0] rx_data_type, rx_hsk_type, tx_hsk_type;
  logic       tx_hsk_send, tx_hsk_sent, m_tvalid, done;
  logic [2:0] status;
  logic [9:0] rx_count;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int m_cnt = 0, tok_cnt = 0, ack_cnt = 0;
  logic [7:0] m_last = 8'd0;
  logic tok_prev = 1'b0, hsk_prev = 1'b0;

  usb_host_xfer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_ep(req_ep), .req_len(req_len),
    .tok_start(tok_start), .tok_type(tok_type), .tok_addr(tok_addr), .tok_ep(tok_ep),
    .tok_sent(tok_sent), .tx_data_start(tx_data_start), .tx_data_type(tx_data_type),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_end(rx_end), .rx_data_type(rx_data_type),
    .rx_hsk_recv(rx_hsk_recv), .rx_hsk_type(rx_hsk_type), .crc_error(crc_error),
    .tx_hsk_send(tx_hsk_send), .tx_hsk_type(tx_hsk_type), .tx_hsk_sent(tx_hsk_sent),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .done(done), .status(status), .rx_count(rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitors sampled mid-cycle
  always @(negedge clk) begin
    if (m_tvalid) begin
      m_cnt  = m_cnt + 1;
      m_last = m_tdata;
    end
    if (tok_start && !tok_prev) tok_cnt = tok_cnt + 1;
    if (tx_hsk_send && !hsk_prev) ack_cnt = ack_cnt + 1;
    tok_prev = tok_start;
    hsk_prev = tx_hsk_send;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [1:0] t, input logic [6:0] a, input logic [3:0] e,
                        input logic [9:0] l);
    int n = 0;
    while (!req_ready && n < 200) begin step(); n++; end
    if (n >= 200) check_eq("req_ready_wait", 32'(req_ready), 32'd1);
    req_type = t; req_addr = a; req_ep = e; req_len = l; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic serve_token();
    int n = 0;
    while (!tok_start && n < 200) begin step(); n++; end
    if (n >= 200) check_eq("tok_wait", 32'(tok_start), 32'd1);
    tok_sent = 1'b1;
    step();
    tok_sent = 1'b0;
  endtask

  task automatic hsk(input logic [1:0] t);
    rx_hsk_type = t; rx_hsk_recv = 1'b1;
    step();
    rx_hsk_recv = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [2:0] exp_status);
    int n = 0;
    while (!done && n < 500) begin step(); n++; end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_status"}, 32'(status), 32'(exp_status));
    step();
  endtask

  task automatic in_packet(input int nbytes, input logic [7:0] base, input logic [1:0] pid,
                           input logic bad_crc);
    for (int i = 0; i < nbytes; i++) begin
      rx_tvalid = 1'b1; rx_tdata = base + 8'(i);
      step();
    end
    rx_tvalid = 1'b0;
    rx_end = 1'b1; rx_data_type = pid; crc_error = bad_crc;
    step();
    rx_end = 1'b0; crc_error = 1'b0;
  endtask

  task automatic send_ack();
    step();
    tx_hsk_sent = 1'b1;
    step();
    tx_hsk_sent = 1'b0;
  endtask

  logic [7:0] out_bytes [4];
  logic [7:0] tlast_mask;
  int m0, t0, a0, n;

  initial begin
    out_bytes[0] = 8'h11; out_bytes[1] = 8'h22; out_bytes[2] = 8'h33; out_bytes[3] = 8'h44;
    rst_n = 1'b0; req_valid = 1'b0; req_type = 2'b00; req_addr = 7'd0; req_ep = 4'd0;
    req_len = 10'd0; tok_sent = 1'b0; s_tdata = 8'd0; s_tvalid = 1'b0; tx_tready = 1'b0;
    rx_tdata = 8'd0; rx_tvalid = 1'b0; rx_end = 1'b0; rx_data_type = 2'b00;
    rx_hsk_recv = 1'b0; rx_hsk_type = 2'b00; crc_error = 1'b0; tx_hsk_sent = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_outs", {tok_start, tx_data_start, tx_tvalid, tx_hsk_send, m_tvalid, done},
             32'd0);
    check_eq("rst_status_count", {status, rx_count}, 32'd0);

    // OUT ep1, 4 bytes, ACK
    do_req(2'b00, 7'd5, 4'd1, 10'd4);
    check_eq("out_tok", {tok_start, tok_type, tok_addr, tok_ep}, {1'b1, 2'b00, 7'd5, 4'd1});
    serve_token();
    check_eq("out_pid", {tx_data_start, tx_data_type}, {1'b1, 2'b00});
    tx_tready = 1'b1;
    tlast_mask = 8'd0;
    for (int i = 0; i < 4; i++) begin
      s_tdata = out_bytes[i]; s_tvalid = 1'b1;
      #1;
      tlast_mask[i] = tx_tlast;
      if (i == 3) check_eq("out_byte3", 32'(tx_tdata), 32'h44);
      step();
    end
    s_tvalid = 1'b0;
    check_eq("out_tlast", 32'(tlast_mask), 32'h08);
    hsk(2'b00);
    wait_done("out_ack", 3'd0);

    // Zero-length OUT ep1 uses DATA1 now; device STALLs
    t0 = tok_cnt;
    do_req(2'b00, 7'd5, 4'd1, 10'd0);
    serve_token();
    s_tvalid = 1'b1;
    #1;
    check_eq("zlp_pid", {tx_data_start, tx_tlast, tx_tvalid, tx_data_type},
             {1'b1, 1'b1, 1'b0, 2'b10});
    step();
    s_tvalid = 1'b0;
    check_eq("zlp_one_cycle", {tx_data_start, tx_tlast}, 32'd0);
    hsk(2'b11);
    wait_done("out_stall", 3'd3);
    check_eq("stall_tokens", tok_cnt - t0, 32'd1);

    // IN ep2: DATA0, good CRC
    m0 = m_cnt; a0 = ack_cnt;
    do_req(2'b10, 7'd9, 4'd2, 10'd0);
    serve_token();
    step(); step();
    in_packet(3, 8'hA1, 2'b00, 1'b0);
    check_eq("in_ack_req", {tx_hsk_send, tx_hsk_type}, {1'b1, 2'b00});
    send_ack();
    check_eq("in_rx_count", 32'(rx_count), 32'd3);
    wait_done("in_good", 3'd0);
    check_eq("in_m_cnt", m_cnt - m0, 32'd3);
    check_eq("in_m_last", 32'(m_last), 32'hA3);
    check_eq("in_acks", ack_cnt - a0, 32'd1);

    // IN ep2 again with DATA0: duplicate
    do_req(2'b10, 7'd9, 4'd2, 10'd0);
    serve_token();
    in_packet(3, 8'hB1, 2'b00, 1'b0);
    send_ack();
    wait_done("in_dup", 3'd6);
    // toggle[2] still 1, so DATA1 is accepted as new
    do_req(2'b10, 7'd9, 4'd2, 10'd0);
    serve_token();
    in_packet(1, 8'hC1, 2'b10, 1'b0);
    send_ack();
    wait_done("in_data1", 3'd0);

    // SETUP ep0: length forced to 8
    do_req(2'b11, 7'd0, 4'd0, 10'd3);
    serve_token();
    check_eq("setup_pid", 32'(tx_data_type), 32'd0);
    tlast_mask = 8'd0;
    for (int i = 0; i < 8; i++) begin
      s_tdata = 8'(i); s_tvalid = 1'b1;
      #1;
      tlast_mask[i] = tx_tlast;
      step();
    end
    s_tvalid = 1'b0;
    check_eq("setup_tlast", 32'(tlast_mask), 32'h80);
    hsk(2'b00);
    wait_done("setup", 3'd0);
    do_req(2'b00, 7'd0, 4'd0, 10'd0);
    serve_token();
    check_eq("setup_toggle", 32'(tx_data_type), 32'h2);
    step();
    hsk(2'b01);
    wait_done("nyet", 3'd1);

    // IN NAK four times
    t0 = tok_cnt;
    do_req(2'b10, 7'd3, 4'd3, 10'd0);
    for (int i = 0; i < 4; i++) begin
      serve_token();
      hsk(2'b10);
    end
    wait_done("nak", 3'd2);
    check_eq("nak_tokens", tok_cnt - t0, 32'd4);

    // IN silence: four 92-cycle waits
    t0 = tok_cnt;
    do_req(2'b10, 7'd3, 4'd3, 10'd0);
    for (int i = 0; i < 4; i++) begin
      serve_token();
      n = 0;
      while (!tok_start && !done && n < 300) begin step(); n++; end
      check_eq("tmo_wait", n, 32'd92);
    end
    wait_done("tmo", 3'd4);
    check_eq("tmo_tokens", tok_cnt - t0, 32'd4);

    // IN CRC error then good packet
    a0 = ack_cnt;
    do_req(2'b10, 7'd4, 4'd4, 10'd0);
    serve_token();
    in_packet(2, 8'hD0, 2'b00, 1'b1);
    check_eq("crc_retoken", {tok_start, tx_hsk_send}, {1'b1, 1'b0});
    serve_token();
    in_packet(1, 8'hE0, 2'b00, 1'b0);
    send_ack();
    wait_done("crc_recover", 3'd0);
    check_eq("crc_acks", ack_cnt - a0, 32'd1);

    // Reset during TX_DATA on ep1 (toggle[1]=1 before reset)
    do_req(2'b00, 7'd5, 4'd1, 10'd4);
    serve_token();
    s_tdata = 8'h55; s_tvalid = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    check_eq("rst_mid_outs", {tok_start, tx_data_start, done, tx_hsk_send}, 32'd0);
    rst_n = 1'b1; s_tvalid = 1'b0;
    step();
    check_eq("rst_mid_ready", {req_ready, done}, {1'b1, 1'b0});
    do_req(2'b00, 7'd5, 4'd1, 10'd0);
    serve_token();
    check_eq("rst_toggle_clr", 32'(tx_data_type), 32'd0);
    step();
    hsk(2'b00);
    wait_done("post_rst", 3'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
